// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter with round-robin selection and in-order response routing.
// Define OBI_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module obi_rr_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_MASTERS-1:0]              m_req_i,
   output logic [NUM_MASTERS-1:0]              m_gnt_o,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [NUM_MASTERS-1:0]              m_we_i,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [NUM_MASTERS-1:0]              m_rvalid_o,
   output logic [DATA_WIDTH-1:0]               m_rdata_o,
   output logic                                s_req_o,
   input  logic                                s_gnt_i,
   output logic [ADDR_WIDTH-1:0]               s_addr_o,
   output logic                                s_we_o,
   output logic [DATA_WIDTH/8-1:0]             s_be_o,
   output logic [DATA_WIDTH-1:0]               s_wdata_o,
   input  logic                                s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               s_rdata_i,
   output logic                                err_o
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int SEL_W = $clog2(NUM_MASTERS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [SEL_W-1:0] scan_sel;
   logic [SEL_W-1:0] sel;
   logic             pending_vld;
   logic [SEL_W-1:0] pending_sel;
   logic             handshake;
   logic             pop;
   logic [SEL_W-1:0] head_sel;
   logic [SEL_W-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

`ifdef OBI_ARB_FIXED_PRIO_EN
   always_comb begin
      scan_sel = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (m_req_i[i]) begin
            scan_sel = SEL_W'(i);
         end
      end
   end
`else
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MASTERS - 1);

   logic [SEL_W-1:0] rr_ptr;
   logic             found;

   // Two passes: first the masters at or above rr_ptr, then wrap to those below it.
   always_comb begin
      scan_sel = rr_ptr;
      found    = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && m_req_i[i] && (SEL_W'(i) >= rr_ptr)) begin
            found    = 1'b1;
            scan_sel = SEL_W'(i);
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && m_req_i[i] && (SEL_W'(i) < rr_ptr)) begin
            found    = 1'b1;
            scan_sel = SEL_W'(i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
      end
   end
`endif

   assign sel       = pending_vld ? pending_sel : scan_sel;
   assign s_req_o   = rst_ni && (|m_req_i) && (count < CNT_MAX);
   assign handshake = s_req_o && s_gnt_i;
   assign pop       = rst_ni && s_rvalid_i && (count != '0);
   assign head_sel  = fifo_mem[rd_ptr];
   assign m_rdata_o = s_rdata_i;

   always_comb begin
      s_addr_o   = '0;
      s_we_o     = 1'b0;
      s_be_o     = '0;
      s_wdata_o  = '0;
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (s_req_o && (sel == SEL_W'(i))) begin
            s_addr_o   = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_we_o     = m_we_i[i];
            s_be_o     = m_be_i[i*BE_W +: BE_W];
            s_wdata_o  = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            m_gnt_o[i] = s_gnt_i;
         end
         m_rvalid_o[i] = pop && (head_sel == SEL_W'(i));
      end
   end

   // The stalled selection is locked so the slave sees stable fields until it grants.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending_vld <= 1'b0;
         pending_sel <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_o       <= 1'b0;
      end else begin
         if (handshake) begin
            pending_vld <= 1'b0;
         end else if (s_req_o && !s_gnt_i) begin
            pending_vld <= 1'b1;
            pending_sel <= sel;
         end
         if (handshake) begin
            fifo_mem[wr_ptr] <= sel;
            wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({handshake, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (s_rvalid_i && (count == '0)) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed self-checking bench for obi_rr_arbiter with three masters and two outstanding slots.
module tb_obi_rr_arbiter;

   logic         clk;
   logic         rst_n;
   logic [2:0]   m_req;
   logic [2:0]   m_gnt;
   logic [95:0]  m_addr;
   logic [2:0]   m_we;
   logic [11:0]  m_be;
   logic [95:0]  m_wdata;
   logic [2:0]   m_rvalid;
   logic [31:0]  m_rdata;
   logic         s_req;
   logic         s_gnt;
   logic [31:0]  s_addr;
   logic         s_we;
   logic [3:0]   s_be;
   logic [31:0]  s_wdata;
   logic         s_rvalid;
   logic [31:0]  s_rdata;
   logic         err;

   int checks = 0;
   int errors = 0;
   int exp_sel [6];

   obi_rr_arbiter #(
      .NUM_MASTERS(3),
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .m_req_i(m_req),
      .m_gnt_o(m_gnt),
      .m_addr_i(m_addr),
      .m_we_i(m_we),
      .m_be_i(m_be),
      .m_wdata_i(m_wdata),
      .m_rvalid_o(m_rvalid),
      .m_rdata_o(m_rdata),
      .s_req_o(s_req),
      .s_gnt_i(s_gnt),
      .s_addr_o(s_addr),
      .s_we_o(s_we),
      .s_be_o(s_be),
      .s_wdata_o(s_wdata),
      .s_rvalid_i(s_rvalid),
      .s_rdata_i(s_rdata),
      .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [2:0] req, input logic gnt,
                                input logic rv, input logic [31:0] rd);
      @(negedge clk);
      rst_n    = rst;
      m_req    = req;
      s_gnt    = gnt;
      s_rvalid = rv;
      s_rdata  = rd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   initial begin
`ifdef OBI_ARB_FIXED_PRIO_EN
      exp_sel = '{0, 0, 0, 0, 0, 0};
`else
      exp_sel = '{0, 1, 2, 0, 1, 2};
`endif
      rst_n    = 1'b0;
      m_req    = 3'b111;
      s_gnt    = 1'b1;
      s_rvalid = 1'b0;
      s_rdata  = 32'h0;
      m_addr   = {32'hA000_0020, 32'hA000_0010, 32'hA000_0000};
      m_we     = 3'b101;
      m_be     = 12'h421;
      m_wdata  = {32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

      $display("[TB] reset with all masters requesting");
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b0, 3'b111, 1'b1, 1'b0, 32'h0);
         checkOutput("reset_gnt", 32'(m_gnt), 32'h0);
         checkOutput("reset_sreq", 32'(s_req), 32'h0);
         checkOutput("reset_rvalid", 32'(m_rvalid), 32'h0);
         checkOutput("reset_err", 32'(err), 32'h0);
      end

      $display("[TB] continuous requests, one response per cycle");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 3'b111, 1'b1, (k > 0), 32'hC0DE_0000 + 32'(k));
         checkOutput("rr_gnt", 32'(m_gnt), 32'(1 << exp_sel[k]));
         checkOutput("rr_addr", s_addr, 32'hA000_0000 + 32'(16 * exp_sel[k]));
         if (k > 0) begin
            checkOutput("rr_rvalid", 32'(m_rvalid), 32'(1 << exp_sel[k-1]));
            checkOutput("rr_rdata", m_rdata, 32'hC0DE_0000 + 32'(k));
         end else begin
            checkOutput("first_we", 32'(s_we), 32'h1);
            checkOutput("first_be", 32'(s_be), 32'h1);
            checkOutput("first_wdata", s_wdata, 32'h5000_0000);
         end
      end
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'h1111_0000);
      checkOutput("rr_drain_rvalid", 32'(m_rvalid), 32'(1 << exp_sel[5]));
      checkOutput("idle_sreq", 32'(s_req), 32'h0);

      $display("[TB] stall hold");
      m_addr[63:32] = 32'h0002_0010;
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_sreq", 32'(s_req), 32'h1);
      checkOutput("stall_addr0", s_addr, 32'h0002_0010);
      checkOutput("stall_gnt0", 32'(m_gnt), 32'h0);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 3'b011, 1'b0, 1'b0, 32'h0);
         checkOutput("stall_addr", s_addr, 32'h0002_0010);
         checkOutput("stall_gnt", 32'(m_gnt), 32'h0);
      end
      applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 32'h0);
      checkOutput("stall_release_gnt", 32'(m_gnt), 32'h2);
      checkOutput("stall_release_addr", s_addr, 32'h0002_0010);
      applyStimulus(1'b1, 3'b011, 1'b1, 1'b0, 32'h0);
      checkOutput("after_stall_gnt", 32'(m_gnt), 32'h1);
      checkOutput("after_stall_addr", s_addr, 32'hA000_0000);

      $display("[TB] outstanding limit");
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("full_sreq", 32'(s_req), 32'h0);
      checkOutput("full_gnt", 32'(m_gnt), 32'h0);
      checkOutput("full_addr", s_addr, 32'h0);
      checkOutput("full_wdata", s_wdata, 32'h0);
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b1, 32'h0BAD_F00D);
      checkOutput("full_pop_sreq", 32'(s_req), 32'h0);
      checkOutput("full_pop_rvalid", 32'(m_rvalid), 32'h2);
      checkOutput("full_pop_rdata", m_rdata, 32'h0BAD_F00D);
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("freed_sreq", 32'(s_req), 32'h1);
      checkOutput("freed_gnt", 32'(m_gnt), 32'h1);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'h2222_0000);
         checkOutput("limit_drain_rvalid", 32'(m_rvalid), 32'h1);
      end

      $display("[TB] response routing");
      applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 32'h0);
      checkOutput("route_gnt2", 32'(m_gnt), 32'h4);
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("route_gnt0", 32'(m_gnt), 32'h1);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF);
      checkOutput("route_rvalid2", 32'(m_rvalid), 32'h4);
      checkOutput("route_rdata2", m_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'h1234_5678);
      checkOutput("route_rvalid0", 32'(m_rvalid), 32'h1);
      checkOutput("route_rdata0", m_rdata, 32'h1234_5678);
      checkOutput("no_err_yet", 32'(err), 32'h0);

      $display("[TB] spurious response");
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF);
      checkOutput("spurious_rvalid", 32'(m_rvalid), 32'h0);
      checkOutput("spurious_err_before", 32'(err), 32'h0);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
         checkOutput("spurious_err_held", 32'(err), 32'h1);
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
      checkOutput("err_until_reset", 32'(err), 32'h1);
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 32'h0);
      checkOutput("err_cleared", 32'(err), 32'h0);
      checkOutput("post_reset_gnt", 32'(m_gnt), 32'h1);

      $display("[TB] reset with a transaction outstanding");
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
      checkOutput("midreset_sreq", 32'(s_req), 32'h0);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 32'h7777_7777);
      checkOutput("late_rvalid_dropped", 32'(m_rvalid), 32'h0);
      checkOutput("late_err_before", 32'(err), 32'h0);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      checkOutput("late_err_set", 32'(err), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Parametrised N-master to 1-slave OBI arbiter. Successor to the fixed two-port instruction/data RAM arbiter.
- Arbitrates NUM_MASTERS OBI requesters onto one shared OBI slave port using round-robin priority.
- Tracks up to MAX_OUTSTANDING accepted transactions and routes each response back to the master that issued it.
- Sits between the core/DMA masters and the SoC memory mux/OBI-WB bridge.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_gnt_o  out  NUM_MASTERS  per-master grant
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at slice i
- m_we_i  in  NUM_MASTERS  write enable
- m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  byte enables
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write data
- m_rvalid_o  out  NUM_MASTERS  per-master response valid
- m_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_addr_o  out  ADDR_WIDTH  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  DATA_WIDTH/8  slave byte enables
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave read data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, rst_ni=0 at clk_i edge):
  - rr_ptr=0, pending_vld=0, FIFO count=0, FIFO pointers=0, err_o=0.
  - Outputs are combinational from cleared state, so m_gnt_o=0, m_rvalid_o=0, s_req_o=0 while m_req_i=0.
  - Reset mid-transaction discards all outstanding entries; late slave rvalids after reset set err_o.
- Selection:
  - If pending_vld=1, sel=pending_sel.
  - Otherwise sel is the first requesting master scanning from rr_ptr upward, wrapping modulo NUM_MASTERS.
- Slave request:
  - s_req_o = (|m_req_i) && (count < MAX_OUTSTANDING).
  - s_addr_o, s_we_o, s_be_o, s_wdata_o are the sel slice; they are 0 when s_req_o=0.
  - A full FIFO blocks requests even if s_rvalid_i pops in the same cycle. There is no rvalid->req combinational path.
- Grant: m_gnt_o[i] = s_req_o && s_gnt_i && (sel==i). This is combinational, zero added latency.
- Stability (OBI rule): if s_req_o=1 and s_gnt_i=0, latch pending_vld=1 and pending_sel=sel. Selection and slave-side fields then hold until granted, and pending_vld clears on handshake.
- Handshake (s_req_o && s_gnt_i):
  - Push sel into the routing FIFO.
  - rr_ptr <= (sel+1) mod NUM_MASTERS.
- Response: on s_rvalid_i with count>0, pop the head and drive m_rvalid_o[head]=1 in the same cycle, with m_rdata_o=s_rdata_i.
- Simultaneous push and pop: count unchanged; pointers advance independently and wrap at MAX_OUTSTANDING.
- s_rvalid_i with count==0: ignored, no m_rvalid_o, count stays 0; err_o <= 1 and holds until reset.
- A response is never routed to a master other than the one whose request was granted; order is strictly FIFO.

Optional Feature:
- Macro OBI_ARB_FIXED_PRIO_EN.
- Defined: rr_ptr is removed. sel is the lowest-index requesting master (pending lock still applies). Starvation of high-index masters is permitted.
- Undefined: round-robin as above.

Test Plan:
- Reset: hold rst_ni=0 two cycles with all m_req_i=1 -> m_gnt_o=0, m_rvalid_o=0, err_o=0, s_req_o=0 during reset. After release, master 0 is granted first.
- Round-robin: N=3, all requesting continuously, s_gnt_i=1 -> grants in order 0,1,2,0,1,2. In fixed-priority build, master 0 only.
- Stall hold: master 1 requests addr 0x0002_0010, s_gnt_i=0 for 3 cycles while master 0 raises req -> s_addr_o stays 0x0002_0010. Master 1 is granted on cycle 4; master 0 is granted next.
- Outstanding limit: MAX_OUTSTANDING=2, two grants, no rvalid -> s_req_o=0 on the third request. One s_rvalid_i, then the next cycle s_req_o=1.
- Routing: grant m2 then m0, rvalid with rdata 0xDEADBEEF then 0x12345678 -> m_rvalid_o[2] with 0xDEADBEEF, then m_rvalid_o[0] with 0x12345678.
- Spurious response: s_rvalid_i=1 with count=0 -> m_rvalid_o=0, err_o=1 and held until rst_ni=0.
